// File: rtl/pic_irr_resolver.sv
// PIC request front end: IRR capture (edge/level), rotating fully nested priority
// resolution against the ISR, INT generation and the two-pulse INTA sequencer.
module pic_irr_resolver (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic       level_triggered,
    input  logic [7:0] interrupt_mask,
    input  logic [7:0] in_service_register,
    input  logic [2:0] lowest_priority,
    input  logic       inta,
    output logic [7:0] interrupt_request,
    output logic       int_out,
    output logic [7:0] set_isr,
    output logic [2:0] vector_index,
    output logic       vector_valid,
    output logic       spurious,
    output logic [1:0] debug_state
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_PENDING   = 2'd1;
    localparam logic [1:0] S_ACK1_WAIT = 2'd2;

    logic [1:0] state;
    logic [1:0] state_next;
    logic [7:0] ir_prev;
    logic [7:0] eligible;
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] win_rank;
    logic       isr_found;
    logic [2:0] isr_rank;
    logic       qualify;
    logic       freeze;
    logic       ack1_hit;
    logic [7:0] ack_clear;
    logic [7:0] irr_next;
    logic [2:0] latched_idx;
    logic       latched_spurious;

    assign eligible    = interrupt_request & ~interrupt_mask;
    assign debug_state = state;
    assign freeze      = (state == S_ACK1_WAIT);

    // Scan ranks from lowest to highest priority so the highest-priority hit is kept last.
    always_comb begin
        logic [2:0] idx;
        win_found = 1'b0;
        win_idx   = 3'd0;
        win_rank  = 3'd0;
        isr_found = 1'b0;
        isr_rank  = 3'd0;
        idx       = 3'd0;
        for (int r = 7; r >= 0; r--) begin
            idx = 3'(r) + lowest_priority + 3'd1;
            if (eligible[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
                win_rank  = 3'(r);
            end
            if (in_service_register[idx]) begin
                isr_found = 1'b1;
                isr_rank  = 3'(r);
            end
        end
    end

    assign qualify   = win_found && (!isr_found || (win_rank < isr_rank));
    assign ack1_hit  = (state == S_PENDING) && inta && qualify;
    assign ack_clear = ack1_hit ? (8'h01 << win_idx) : 8'h00;

    // During ACK1_WAIT the register may only lose bits; edges seen then are dropped.
    always_comb begin
        irr_next = 8'h00;
        if (level_triggered)
            irr_next = ir & (freeze ? interrupt_request : 8'hff) & ~ack_clear;
        else
            irr_next = (interrupt_request | (ir & ~ir_prev & {8{~freeze}})) & ir & ~ack_clear;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (qualify) state_next = S_PENDING;
            S_PENDING: begin
                if (inta)          state_next = S_ACK1_WAIT;
                else if (!qualify) state_next = S_IDLE;
            end
            S_ACK1_WAIT: if (inta) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state             <= S_IDLE;
            ir_prev           <= 8'h00;
            interrupt_request <= 8'h00;
            int_out           <= 1'b0;
            set_isr           <= 8'h00;
            vector_index      <= 3'd0;
            vector_valid      <= 1'b0;
            spurious          <= 1'b0;
            latched_idx       <= 3'd0;
            latched_spurious  <= 1'b0;
        end else begin
            state             <= state_next;
            ir_prev           <= ir;
            interrupt_request <= irr_next;
            int_out           <= (state_next != S_IDLE);
            set_isr           <= ack_clear;
            vector_valid      <= 1'b0;
            spurious          <= 1'b0;
            if (state == S_PENDING && inta) begin
                latched_idx      <= qualify ? win_idx : 3'd7;
                latched_spurious <= !qualify;
            end
            if (state == S_ACK1_WAIT && inta) begin
                vector_valid <= 1'b1;
                vector_index <= latched_idx;
                spurious     <= latched_spurious;
            end
        end
    end

endmodule

// File: tb/tb_pic_irr_resolver.sv
// Directed bench for pic_irr_resolver: hand-computed expectations for capture,
// priority, nesting, spurious, freeze and reset behaviour.
module tb_pic_irr_resolver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] ir;
    logic       level_triggered;
    logic [7:0] interrupt_mask;
    logic [7:0] in_service_register;
    logic [2:0] lowest_priority;
    logic       inta;
    logic [7:0] interrupt_request;
    logic       int_out;
    logic [7:0] set_isr;
    logic [2:0] vector_index;
    logic       vector_valid;
    logic       spurious;
    logic [1:0] debug_state;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    pic_irr_resolver dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .ir                  (ir),
        .level_triggered     (level_triggered),
        .interrupt_mask      (interrupt_mask),
        .in_service_register (in_service_register),
        .lowest_priority     (lowest_priority),
        .inta                (inta),
        .interrupt_request   (interrupt_request),
        .int_out             (int_out),
        .set_isr             (set_isr),
        .vector_index        (vector_index),
        .vector_valid        (vector_valid),
        .spurious            (spurious),
        .debug_state         (debug_state)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Two INTA pulses with a gap cycle; checks the strobes after each.
    task automatic do_ack(input string tag, input logic [7:0] exp_set,
                          input logic [2:0] exp_idx, input logic exp_spur);
        inta = 1'b1; tick(); inta = 1'b0;
        check({tag, "_set_isr"}, set_isr, exp_set);
        check({tag, "_int_hold"}, {7'd0, int_out}, 8'd1);
        tick();
        check({tag, "_set_isr_1cyc"}, set_isr, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        check({tag, "_vvalid"}, {7'd0, vector_valid}, 8'd1);
        check({tag, "_vindex"}, {5'd0, vector_index}, {5'd0, exp_idx});
        check({tag, "_spurious"}, {7'd0, spurious}, {7'd0, exp_spur});
        check({tag, "_int_drop"}, {7'd0, int_out}, 8'd0);
        tick();
        check({tag, "_vvalid_1cyc"}, {7'd0, vector_valid}, 8'd0);
        check({tag, "_vindex_hold"}, {5'd0, vector_index}, {5'd0, exp_idx});
    endtask

    initial begin
        reset_n = 1'b0; ir = 8'h00; level_triggered = 1'b0; interrupt_mask = 8'h00;
        in_service_register = 8'h00; lowest_priority = 3'd7; inta = 1'b0;
        tick(); tick();
        check("rst_irr", interrupt_request, 8'h00);
        check("rst_int", {7'd0, int_out}, 8'd0);
        check("rst_set", set_isr, 8'h00);
        check("rst_vout", {3'd0, vector_index, vector_valid, spurious}, 8'h00);
        reset_n = 1'b1; tick();

        // Basic edge capture, IR3
        ir = 8'h08; tick();
        check("t1_irr", interrupt_request, 8'h08);
        check("t1_int_early", {7'd0, int_out}, 8'd0);
        tick();
        check("t1_int", {7'd0, int_out}, 8'd1);
        inta = 1'b1; tick(); inta = 1'b0;
        check("t1_set", set_isr, 8'h08);
        check("t1_irr_clr", interrupt_request, 8'h00);
        tick();
        inta = 1'b1; tick(); inta = 1'b0;
        check("t1_vvalid", {7'd0, vector_valid}, 8'd1);
        check("t1_vindex", {5'd0, vector_index}, 8'd3);
        check("t1_int_drop", {7'd0, int_out}, 8'd0);
        tick();
        check("t1_vvalid_1cyc", {7'd0, vector_valid}, 8'd0);
        ir = 8'h00; tick();

        // Simultaneous IR2+IR5, IR0 highest: IR2 then IR5 back-to-back
        ir = 8'h24; tick();
        check("t2_irr", interrupt_request, 8'h24);
        tick();
        do_ack("t2a", 8'h04, 3'd2, 1'b0);
        check("t2_reassert", {7'd0, int_out}, 8'd1);
        do_ack("t2b", 8'h20, 3'd5, 1'b0);
        ir = 8'h00; tick(); tick();

        // Rotated priority: lowest=2 makes IR5 outrank IR2
        lowest_priority = 3'd2;
        ir = 8'h24; tick(); tick();
        do_ack("t2c", 8'h20, 3'd5, 1'b0);
        do_ack("t2d", 8'h04, 3'd2, 1'b0);
        ir = 8'h00; lowest_priority = 3'd7; tick(); tick();

        // Nesting against ISR
        in_service_register = 8'h04;
        ir = 8'h04; tick(); tick(); tick();
        check("t3_blocked", {7'd0, int_out}, 8'd0);
        ir = 8'h06; tick();
        check("t3_irr", interrupt_request, 8'h06);
        tick();
        check("t3_ir1_int", {7'd0, int_out}, 8'd1);
        interrupt_mask = 8'h02; tick();
        check("t3_mask_drop", {7'd0, int_out}, 8'd0);
        ir = 8'h00; tick();
        in_service_register = 8'h00; interrupt_mask = 8'h00; tick(); tick();
        check("t3_clean", {7'd0, int_out}, 8'd0);

        // Level mode: request withdrawn before INTA
        level_triggered = 1'b1;
        ir = 8'h40; tick();
        check("t4_irr", interrupt_request, 8'h40);
        tick();
        check("t4_int", {7'd0, int_out}, 8'd1);
        ir = 8'h00; tick(); tick();
        check("t4_idle", {7'd0, int_out}, 8'd0);
        check("t4_no_set", set_isr, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        check("t4_idle_inta_vv", {7'd0, vector_valid}, 8'd0);
        check("t4_idle_inta_set", set_isr, 8'h00);
        check("t4_idle_inta_int", {7'd0, int_out}, 8'd0);

        // Level mode: qualify drops on the INTA edge -> spurious
        ir = 8'h40; tick(); tick();
        ir = 8'h00; tick();
        check("t4b_pending", {7'd0, int_out}, 8'd1);
        do_ack("t4b", 8'h00, 3'd7, 1'b1);
        level_triggered = 1'b0; tick();

        // Freeze: IR0 edge during ACK1_WAIT is lost
        ir = 8'h08; tick(); tick();
        inta = 1'b1; tick(); inta = 1'b0;
        check("t5_set", set_isr, 8'h08);
        ir = 8'h09; tick();
        check("t5_frozen", interrupt_request, 8'h00);
        inta = 1'b1; tick(); inta = 1'b0;
        check("t5_vindex", {5'd0, vector_index}, 8'd3);
        tick();
        check("t5_lost", interrupt_request, 8'h00);
        check("t5_no_int", {7'd0, int_out}, 8'd0);
        ir = 8'h00; tick();

        // Reset during ACK1_WAIT aborts the sequence
        ir = 8'h02; tick(); tick();
        inta = 1'b1; tick(); inta = 1'b0;
        check("t6_set", set_isr, 8'h02);
        reset_n = 1'b0; tick();
        check("t6_irr", interrupt_request, 8'h00);
        check("t6_int", {7'd0, int_out}, 8'd0);
        check("t6_set_rst", set_isr, 8'h00);
        check("t6_vout", {3'd0, vector_index, vector_valid, spurious}, 8'h00);
        reset_n = 1'b1; ir = 8'h00; inta = 1'b1; tick(); inta = 1'b0;
        check("t6_no_vvalid", {7'd0, vector_valid}, 8'd0);
        check("t6_no_spur", {7'd0, spurious}, 8'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pic_irr_resolver.md
# pic_irr_resolver

Upstream stage of the PIC in-service logic: captures the eight raw IR lines into the interrupt request register (IRR), edge- or level-triggered. It resolves the highest-priority unmasked request against the current in-service bits under fully nested, rotatable priority, and drives INT. A two-pulse INTA sequencer latches the winner, issues a one-cycle set strobe to the in-service register, clears the serviced edge latch and presents the vector index.

## Interface
- No parameters; width fixed at 8 IR lines.
- `clk` input 1 — single system clock; all state updates on rising edge.
- `reset_n` input 1 — synchronous, active-low reset.
- `ir` input 8 — raw interrupt request lines, already synchronous to `clk`.
- `level_triggered` input 1 — 1: level mode (LTIM); 0: edge mode.
- `interrupt_mask` input 8 — IMR; 1 masks the bit.
- `in_service_register` input 8 — current ISR contents from the in-service stage.
- `lowest_priority` input 3 — IR number with lowest priority; highest is (`lowest_priority`+1) mod 8; 3'd7 gives IR0 highest.
- `inta` input 1 — one-cycle pulse per INTA bus cycle, already synchronised.
- `interrupt_request` output 8 — IRR contents.
- `int_out` output 1 — INT to CPU, registered.
- `set_isr` output 8 — one-hot, one-cycle strobe that sets the winning ISR bit.
- `vector_index` output 3 — winning IR number.
- `vector_valid` output 1 — one-cycle strobe: `vector_index` valid for the vector byte.
- `spurious` output 1 — held with `vector_valid`: no request survived to first INTA.

## Operation
- Register `ir_prev` holds the previous cycle's `ir`.
- Edge mode: IRR[i] sets when `ir[i]`=1 and `ir_prev[i]`=0. It clears when `ir[i]`=0, or at ACK1 for the winning bit.
- Level mode: IRR[i] = `ir[i]` registered. The ACK1 clear applies for that cycle only.
- Freeze: in ACK1_WAIT, IRR bits may still clear but never set. Edges arriving during the freeze are lost.
- Eligible = IRR & ~`interrupt_mask`.
- Priority rank of IR i = (i − `lowest_priority` − 1) mod 8; rank 0 is highest. Use 3-bit wrap-around arithmetic.
- Winner = eligible bit with the lowest rank.
- Qualify: a winner exists and its rank is strictly lower than the rank of every set `in_service_register` bit. Equal rank does not qualify. Qualify holds trivially when ISR = 0.
- FSM states:
  - IDLE: `int_out`=0. On qualify → PENDING.
  - PENDING: `int_out`=1. If qualify drops before `inta` → IDLE. On `inta` → ACK1_WAIT and latch winner:
    - If qualify holds this cycle: `set_isr` = one-hot(winner) for 1 cycle; clear the IRR bit.
    - Otherwise: winner forced to 7, `set_isr`=0, spurious latched.
  - ACK1_WAIT: `int_out` stays 1. On `inta` → IDLE, with `vector_valid`=1 for 1 cycle and `vector_index` = latched winner. `spurious` is asserted alongside if latched.
  - `inta` in IDLE is ignored; no outputs change.
  - ISR/mask/priority changes during ACK1_WAIT do not alter the latched winner.
- `vector_index` holds its last value outside strobes.

## Timing
- Reset (`reset_n`=0 at a clock edge): FSM=IDLE; `ir_prev`, `interrupt_request`, `set_isr`=0; `int_out`, `vector_index`, `vector_valid`, `spurious`=0. Reset mid-sequence aborts it with no strobe issued.
- Edge mode: `ir` rises before edge E → IRR set at E → `int_out`=1 at E+1 if qualified.
- `inta` sampled at edge A (PENDING) → `set_isr` and IRR clear visible after A, for one cycle.
- Second `inta` at edge B → `vector_valid` for the cycle after B; `int_out`=0 after B.
- Back-to-back: a remaining qualified request reasserts `int_out` no earlier than B+1. One idle cycle is mandatory.
- `inta` on the same edge that qualify drops in PENDING: treated as spurious.

## Test plan
- Edge, `lowest_priority`=7, mask=0, ISR=0: `ir`=8'h08 rising → IRR=8'h08, `int_out` next cycle; two `inta` pulses → `set_isr`=8'h08, IRR→0, `vector_index`=3, `vector_valid` one cycle.
- Simultaneous `ir`=8'h24: winner IR2. With `lowest_priority`=2, winner is IR5.
- Nesting: ISR=8'h04, request IR2 only → no `int_out`. Request IR1 → `int_out`=1. Mask IR1 → `int_out` drops.
- Spurious: level mode, `ir`=8'h40, `int_out`=1, `ir` drops before first `inta` → FSM returns IDLE, no strobes. Repeat with drop on the `inta` edge → `set_isr`=0, `vector_index`=7, `spurious`=1.
- Freeze/reset: new edge on IR0 during ACK1_WAIT is not captured. `reset_n`=0 in ACK1_WAIT → all outputs 0, no `vector_valid`.
